arbitro_uart_tx: RTL and testbench
==================================

ARBITRO_UART_TX -- requirements
Module: arbitro_uart_tx

Interface
REQ-001 The block SHALL have parameter N_REQ, default 3, meaning the number of requesters sharing the UART transmitter.
REQ-002 The block SHALL have parameter LARGURA_DADO, default 8, meaning the width of one transmitted byte.
REQ-003 The block SHALL have parameter TIMEOUT_CICLOS, default 50000, meaning the maximum cycles allowed for one UART byte.
REQ-004 clock  input  1  system clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; forces the reset state of REQ-030.
REQ-006 pedido  input  N_REQ  per-requester frame request; held high for a whole multi-byte frame.
REQ-007 envia_byte  input  N_REQ  per-requester one-cycle strobe; byte on its dado slice is ready.
REQ-008 dado  input  N_REQ*LARGURA_DADO  packed bytes; slice i belongs to requester i.
REQ-009 concede  output  N_REQ  one-hot grant; at most one bit is high.
REQ-010 byte_enviado  output  N_REQ  one-cycle pulse to the owner when its byte completes.
REQ-011 iniciar_transmissao_uart_tx  output  1  one-cycle start pulse to UART TX.
REQ-012 dado_uart_tx  output  LARGURA_DADO  registered byte presented to UART TX.
REQ-013 acabou_transmissao_uart_tx  input  1  one-cycle done pulse from UART TX.
REQ-014 erro_timeout  output  1  one-cycle pulse on a UART timeout.
REQ-015 db_estado  output  3  current state code for debug.

Function
REQ-016 The FSM SHALL have these states and codes: OCIOSO=0, CONCEDE=1, ESPERA_BYTE=2, INICIA_TX=3, ESPERA_TX=4, LIBERA=5; any other code SHALL go to OCIOSO.
REQ-017 In OCIOSO, with any pedido bit high, the block SHALL select the owner round-robin, searching from (ultimo+1) mod N_REQ upward, and go to CONCEDE; with no pedido bit high it SHALL stay in OCIOSO.
REQ-018 In CONCEDE, the block SHALL register the owner, assert concede[owner] from the next cycle, and go to ESPERA_BYTE.
REQ-019 concede[owner] SHALL stay high in ESPERA_BYTE, INICIA_TX and ESPERA_TX, and SHALL be low in all other states.
REQ-020 In ESPERA_BYTE, when envia_byte[owner] is high, the block SHALL latch dado slice owner into dado_uart_tx and go to INICIA_TX.
REQ-021 In ESPERA_BYTE, when pedido[owner] is low and envia_byte[owner] is low, the block SHALL go to LIBERA; envia_byte takes priority when both events occur in the same cycle.
REQ-022 envia_byte and dado from non-owners SHALL be ignored and SHALL NOT be queued.
REQ-023 INICIA_TX SHALL assert iniciar_transmissao_uart_tx for exactly one cycle, clear the timeout counter, and go to ESPERA_TX.
REQ-024 In ESPERA_TX, acabou_transmissao_uart_tx SHALL pulse byte_enviado[owner] for one cycle. The block SHALL then go to ESPERA_BYTE if pedido[owner] is high, otherwise to LIBERA.
REQ-025 If pedido[owner] falls during ESPERA_TX, the current byte SHALL still complete before release.
REQ-026 The timeout counter SHALL increment every cycle in ESPERA_TX and saturate. On reaching TIMEOUT_CICLOS-1 without a done pulse, the block SHALL pulse erro_timeout, withhold byte_enviado, and go to LIBERA.
REQ-027 LIBERA SHALL last one cycle with concede all-zero, set ultimo=owner, and go to OCIOSO.
REQ-028 Minimum latency SHALL be: pedido rise to concede = 2 cycles; envia_byte to start pulse = 2 cycles.
REQ-029 dado_uart_tx SHALL hold its value from latch until the next latch.

Reset
REQ-030 On reset, the block SHALL set state=OCIOSO, ultimo=N_REQ-1 (so requester 0 wins first), and concede=0. It SHALL also set byte_enviado=0, iniciar_transmissao_uart_tx=0, erro_timeout=0, dado_uart_tx=0, counter=0 and db_estado=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no byte_enviado or erro_timeout pulse.

Structure
REQ-032 State codes and the default TIMEOUT_CICLOS SHALL reside in the shared package used by the AstroGenius UCs.
REQ-033 Round-robin selection SHALL be one combinational sub-module, seletor_round_robin (inputs pedido and ultimo; outputs valido and indice); the FSM, counter and registers remain in arbitro_uart_tx.

Verification
REQ-034 The bench SHALL cover: pedido=3'b001, three envia_byte strobes of 8'hA1, 8'hA2, 8'hA3, each done after 10 cycles -> three start pulses with dado_uart_tx A1/A2/A3, three byte_enviado[0] pulses, then LIBERA and concede=0.
REQ-035 The bench SHALL cover: pedido=3'b111 held, one byte per frame, then frame drop -> concede order 0,1,2,0.
REQ-036 The bench SHALL cover: owner 1 granted, envia_byte[0] and envia_byte[2] strobed -> no start pulse, dado_uart_tx unchanged.
REQ-037 The bench SHALL cover: TIMEOUT_CICLOS=20, no done pulse -> erro_timeout pulse 20 cycles after start, no byte_enviado, state to OCIOSO.
REQ-038 The bench SHALL cover: pedido[owner] dropped during ESPERA_TX -> done pulse still yields byte_enviado, then LIBERA.
REQ-039 The bench SHALL cover: reset pulsed in ESPERA_TX -> all outputs 0 next cycle, db_estado=0.

Source files
------------

// File: rtl/arbitro_uart_tx_pkg.sv
// Shared definitions for the AstroGenius UART transmit arbiter: FSM state codes,
// the default byte timeout and a width helper.
package arbitro_uart_tx_pkg;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        CONCEDE     = 3'd1,
        ESPERA_BYTE = 3'd2,
        INICIA_TX   = 3'd3,
        ESPERA_TX   = 3'd4,
        LIBERA      = 3'd5
    } estado_t;

    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 50000;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned largura_minima(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_uart_tx_seletor_round_robin.sv
// Combinational round-robin picker: first active request found searching upward
// from the requester after the last owner, wrapping around.
module seletor_round_robin
    import arbitro_uart_tx_pkg::*;
#(
    parameter int unsigned N_REQ = 3,
    localparam int unsigned LARGURA_IDX = largura_minima(N_REQ)
) (
    input  logic [N_REQ-1:0]       pedido,
    input  logic [LARGURA_IDX-1:0] ultimo,
    output logic                   valido,
    output logic [LARGURA_IDX-1:0] indice
);

    int unsigned             cand;
    logic [LARGURA_IDX-1:0]  cand_idx;

    always_comb begin
        valido   = 1'b0;
        indice   = '0;
        cand     = 0;
        cand_idx = '0;
        // k = N_REQ revisits the previous owner last, so it only wins when alone.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(ultimo) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = LARGURA_IDX'(cand);
            if (!valido && pedido[cand_idx]) begin
                valido = 1'b1;
                indice = cand_idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_uart_tx.sv
// Arbitrates one UART transmitter among N_REQ requesters; a grant spans a whole
// multi-byte frame and each byte is guarded by a timeout.
module arbitro_uart_tx
    import arbitro_uart_tx_pkg::*;
#(
    parameter int unsigned N_REQ          = 3,
    parameter int unsigned LARGURA_DADO   = 8,
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              pedido,
    input  logic [N_REQ-1:0]              envia_byte,
    input  logic [N_REQ*LARGURA_DADO-1:0] dado,
    output logic [N_REQ-1:0]              concede,
    output logic [N_REQ-1:0]              byte_enviado,
    output logic                          iniciar_transmissao_uart_tx,
    output logic [LARGURA_DADO-1:0]       dado_uart_tx,
    input  logic                          acabou_transmissao_uart_tx,
    output logic                          erro_timeout,
    output logic [2:0]                    db_estado
);

    localparam int unsigned LARGURA_IDX = largura_minima(N_REQ);
    localparam int unsigned LARGURA_CNT = largura_minima(TIMEOUT_CICLOS);
    localparam logic [LARGURA_CNT-1:0] LIMITE_CNT   = LARGURA_CNT'(TIMEOUT_CICLOS - 1);
    localparam logic [LARGURA_IDX-1:0] ULTIMO_RESET = LARGURA_IDX'(N_REQ - 1);

    estado_t                 estado_q, estado_d;
    logic [LARGURA_IDX-1:0]  dono_q, dono_d;
    logic [LARGURA_IDX-1:0]  ultimo_q, ultimo_d;
    logic [LARGURA_DADO-1:0] dado_q, dado_d;
    logic [LARGURA_CNT-1:0]  cnt_q, cnt_d;
    logic                    iniciar_q, iniciar_d;
    logic [N_REQ-1:0]        byte_enviado_q, byte_enviado_d;
    logic                    erro_q, erro_d;

    logic                    valido;
    logic [LARGURA_IDX-1:0]  indice;
    logic [N_REQ-1:0]        dono_onehot;
    logic [LARGURA_DADO-1:0] dado_dono;
    logic                    envia_dono;
    logic                    pedido_dono;
    logic                    grant_ativo;

    seletor_round_robin #(
        .N_REQ (N_REQ)
    ) u_seletor (
        .pedido (pedido),
        .ultimo (ultimo_q),
        .valido (valido),
        .indice (indice)
    );

    // Only the owner's slice is ever looked at; other strobes are simply dropped.
    always_comb begin
        dono_onehot = '0;
        dado_dono   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (dono_q == LARGURA_IDX'(i)) begin
                dono_onehot[i] = 1'b1;
                dado_dono      = dado[i*LARGURA_DADO +: LARGURA_DADO];
            end
        end
        envia_dono  = |(envia_byte & dono_onehot);
        pedido_dono = |(pedido & dono_onehot);
    end

    always_comb begin
        estado_d       = estado_q;
        dono_d         = dono_q;
        ultimo_d       = ultimo_q;
        dado_d         = dado_q;
        cnt_d          = cnt_q;
        iniciar_d      = 1'b0;
        byte_enviado_d = '0;
        erro_d         = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (valido) begin
                    dono_d   = indice;
                    estado_d = CONCEDE;
                end
            end
            CONCEDE: begin
                estado_d = ESPERA_BYTE;
            end
            ESPERA_BYTE: begin
                if (envia_dono) begin
                    dado_d   = dado_dono;
                    estado_d = INICIA_TX;
                end else if (!pedido_dono) begin
                    estado_d = LIBERA;
                end
            end
            INICIA_TX: begin
                iniciar_d = 1'b1;
                cnt_d     = '0;
                estado_d  = ESPERA_TX;
            end
            ESPERA_TX: begin
                // A done pulse on the last allowed cycle still counts as success.
                if (acabou_transmissao_uart_tx) begin
                    byte_enviado_d = dono_onehot;
                    estado_d       = pedido_dono ? ESPERA_BYTE : LIBERA;
                end else if (cnt_q == LIMITE_CNT) begin
                    erro_d   = 1'b1;
                    estado_d = LIBERA;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LIBERA: begin
                ultimo_d = dono_q;
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= OCIOSO;
            dono_q         <= '0;
            ultimo_q       <= ULTIMO_RESET;
            dado_q         <= '0;
            cnt_q          <= '0;
            iniciar_q      <= 1'b0;
            byte_enviado_q <= '0;
            erro_q         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            dono_q         <= dono_d;
            ultimo_q       <= ultimo_d;
            dado_q         <= dado_d;
            cnt_q          <= cnt_d;
            iniciar_q      <= iniciar_d;
            byte_enviado_q <= byte_enviado_d;
            erro_q         <= erro_d;
        end
    end

    assign grant_ativo = (estado_q == ESPERA_BYTE) || (estado_q == INICIA_TX) ||
                         (estado_q == ESPERA_TX);
    assign concede                     = grant_ativo ? dono_onehot : '0;
    assign byte_enviado                = byte_enviado_q;
    assign iniciar_transmissao_uart_tx = iniciar_q;
    assign dado_uart_tx                = dado_q;
    assign erro_timeout                = erro_q;
    assign db_estado                   = estado_q;

endmodule

// File: tb/tb_arbitro_uart_tx.sv
// Scoreboard bench for arbitro_uart_tx: a UART stand-in answers start pulses and a
// falling-edge monitor records starts, grants and completions for the tests.
module tb_arbitro_uart_tx;

    localparam int unsigned NR  = 3;
    localparam int unsigned LD  = 8;
    localparam int unsigned TMO = 20;

    logic            clock = 1'b0;
    logic            reset;
    logic [NR-1:0]   pedido;
    logic [NR-1:0]   envia_byte;
    logic [NR*LD-1:0] dado;
    logic [NR-1:0]   concede;
    logic [NR-1:0]   byte_enviado;
    logic            iniciar;
    logic [LD-1:0]   dado_uart_tx;
    logic            acabou;
    logic            erro;
    logic [2:0]      db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] obs_tx[$];
    int         exp_grant[$];
    int         obs_grant[$];
    int         obs_env[$];
    int         n_erro     = 0;
    int         n_multi    = 0;
    int         done_delay = 0;
    int         countdown  = 0;
    int         ciclo      = 0;
    logic [NR-1:0] concede_ant = '0;

    always #5 clock = ~clock;

    arbitro_uart_tx #(
        .N_REQ          (NR),
        .LARGURA_DADO   (LD),
        .TIMEOUT_CICLOS (TMO)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .pedido                      (pedido),
        .envia_byte                  (envia_byte),
        .dado                        (dado),
        .concede                     (concede),
        .byte_enviado                (byte_enviado),
        .iniciar_transmissao_uart_tx (iniciar),
        .dado_uart_tx                (dado_uart_tx),
        .acabou_transmissao_uart_tx  (acabou),
        .erro_timeout                (erro),
        .db_estado                   (db_estado)
    );

    // UART stand-in plus monitor, all on the falling edge.
    initial begin
        acabou = 1'b0;
        forever begin
            @(negedge clock);
            ciclo++;
            acabou = 1'b0;
            if (reset === 1'b1) begin
                countdown = 0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) acabou = 1'b1;
            end
            if (iniciar === 1'b1) begin
                obs_tx.push_back(dado_uart_tx);
                if (done_delay > 0) countdown = done_delay;
            end
            for (int i = 0; i < int'(NR); i++)
                if (byte_enviado[i] === 1'b1) obs_env.push_back(i);
            if (erro === 1'b1) n_erro++;
            if ($countones(concede) > 1) n_multi++;
            if (concede !== concede_ant)
                for (int i = 0; i < int'(NR); i++)
                    if (concede[i] === 1'b1) obs_grant.push_back(i);
            concede_ant = concede;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_grant(input int idx, output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (concede[idx] === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] code, input string nome);
        bit ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (db_estado === code) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: state %0d never reached, last %0d", nome, code, db_estado);
        end
    endtask

    task automatic send_byte(input int owner, input logic [7:0] valor, output int lat);
        envia_byte = '0;
        envia_byte[owner] = 1'b1;
        dado[owner*LD +: LD] = valor;
        exp_tx.push_back(valor);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            envia_byte = '0;
            if (iniciar === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_env(output int idx);
        obs_env.delete();
        idx = -1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (obs_env.size() > 0) begin
                idx = obs_env.pop_front();
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pedido = '0;
        envia_byte = '0;
        dado = '0;
        repeat (2) tick();
        n_checks++;
        if ({concede, byte_enviado, iniciar, erro} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want 0", {concede, byte_enviado, iniciar, erro});
        end
        n_checks++;
        if (dado_uart_tx !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_dado: got %h, want 00", dado_uart_tx);
        end
        n_checks++;
        if (db_estado !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_estado: got %0d, want 0", db_estado);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (db_estado !== 3'd0 || concede !== '0) begin
            n_fail++;
            $display("FAIL idle_no_req: estado %0d concede %b, want 0 and 000", db_estado, concede);
        end
    endtask

    task automatic test_single_frame();
        int lat, idx;
        done_delay = 10;
        pedido = 3'b001;
        wait_grant(0, lat);
        n_checks++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL grant_latency: got %0d cycles, want 2", lat);
        end
        for (int k = 1; k <= 3; k++) begin
            send_byte(0, 8'hA0 + 8'(k), lat);
            n_checks++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL start_latency byte %0d: got %0d cycles, want 2", k, lat);
            end
            wait_env(idx);
            n_checks++;
            if (idx !== 0) begin
                n_fail++;
                $display("FAIL byte_enviado byte %0d: got owner %0d, want 0", k, idx);
            end
        end
        while (exp_tx.size() > 0) begin
            logic [7:0] e = exp_tx.pop_front();
            logic [7:0] o = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL frame_tx_byte: got %h, want %h", o, e);
            end
        end
        pedido = '0;
        wait_state(3'd5, "frame_libera");
        n_checks++;
        if (concede !== '0) begin
            n_fail++;
            $display("FAIL libera_concede: got %b, want 000", concede);
        end
        tick();
        n_checks++;
        if (db_estado !== 3'd0) begin
            n_fail++;
            $display("FAIL libera_to_ocioso: got %0d, want 0", db_estado);
        end
    endtask

    task automatic test_round_robin();
        int lat, idx, owner;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        obs_grant.delete();
        exp_grant.delete();
        obs_tx.delete();
        exp_tx.delete();
        done_delay = 4;
        pedido = 3'b111;
        for (int f = 0; f < 4; f++) begin
            exp_grant.push_back(f % 3);
            owner = 0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (concede !== '0) break;
            end
            for (int i = 0; i < int'(NR); i++) if (concede[i] === 1'b1) owner = i;
            send_byte(owner, 8'hB0 + 8'(f), lat);
            wait_env(idx);
            pedido[owner] = 1'b0;
            wait_state(3'd5, "rr_libera");
            tick();
            pedido[owner] = 1'b1;
        end
        pedido = '0;
        wait_state(3'd0, "rr_idle");
        while (exp_grant.size() > 0) begin
            int e = exp_grant.pop_front();
            int o = (obs_grant.size() > 0) ? obs_grant.pop_front() : -1;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rr_order: got owner %0d, want %0d", o, e);
            end
        end
        while (exp_tx.size() > 0) begin
            logic [7:0] e = exp_tx.pop_front();
            logic [7:0] o = (obs_tx.size() > 0) ? obs_tx.pop_front() : 8'hxx;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rr_tx_byte: got %h, want %h", o, e);
            end
        end
    endtask

    task automatic test_non_owner();
        int lat;
        int starts0;
        pedido = 3'b010;
        wait_grant(1, lat);
        starts0 = obs_tx.size();
        for (int c = 0; c < 3; c++) begin
            envia_byte = 3'b101;
            dado = {8'h5A, 8'h00, 8'hC3} ^ 24'(c);
            tick();
        end
        envia_byte = '0;
        repeat (4) tick();
        n_checks++;
        if (obs_tx.size() !== starts0) begin
            n_fail++;
            $display("FAIL non_owner_start: got %0d starts, want 0", obs_tx.size() - starts0);
        end
        n_checks++;
        if (dado_uart_tx !== 8'hB3) begin
            n_fail++;
            $display("FAIL non_owner_dado: got %h, want b3", dado_uart_tx);
        end
        n_checks++;
        if (db_estado !== 3'd2 || concede !== 3'b010) begin
            n_fail++;
            $display("FAIL non_owner_hold: estado %0d concede %b, want 2 and 010",
                     db_estado, concede);
        end
        pedido = '0;
        wait_state(3'd0, "non_owner_idle");
    endtask

    task automatic test_timeout();
        int lat, t_start, t_erro, n_env0;
        done_delay = 0;
        obs_env.delete();
        pedido = 3'b001;
        wait_grant(0, lat);
        send_byte(0, 8'hC1, lat);
        t_start = ciclo;
        t_erro = -1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (erro === 1'b1) begin
                t_erro = ciclo;
                break;
            end
        end
        n_checks++;
        if (t_erro - t_start !== int'(TMO)) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d cycles, want %0d", t_erro - t_start, TMO);
        end
        n_env0 = obs_env.size();
        n_checks++;
        if (n_env0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_no_env: got %0d pulses, want 0", n_env0);
        end
        n_checks++;
        if (db_estado !== 3'd5) begin
            n_fail++;
            $display("FAIL timeout_libera: got %0d, want 5", db_estado);
        end
        pedido = '0;
        tick();
        n_checks++;
        if (db_estado !== 3'd0 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_ocioso: estado %0d erro %b, want 0 and 0", db_estado, erro);
        end
        exp_tx.delete();
        obs_tx.delete();
    endtask

    task automatic test_drop_during_tx();
        int lat, idx;
        done_delay = 10;
        pedido = 3'b001;
        wait_grant(0, lat);
        send_byte(0, 8'hD1, lat);
        pedido = '0;
        wait_env(idx);
        n_checks++;
        if (idx !== 0) begin
            n_fail++;
            $display("FAIL drop_env: got owner %0d, want 0", idx);
        end
        n_checks++;
        if (db_estado !== 3'd5 || concede !== '0) begin
            n_fail++;
            $display("FAIL drop_libera: estado %0d concede %b, want 5 and 000",
                     db_estado, concede);
        end
        n_checks++;
        if ((obs_tx.size() > 0 ? obs_tx.pop_front() : 8'hxx) !== exp_tx.pop_front()) begin
            n_fail++;
            $display("FAIL drop_tx_byte: start byte wrong or missing, want d1");
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_erro0, n_env0;
        done_delay = 0;
        wait_state(3'd0, "mid_idle");
        pedido = 3'b001;
        wait_grant(0, lat);
        send_byte(0, 8'hE1, lat);
        repeat (3) tick();
        n_checks++;
        if (db_estado !== 3'd4) begin
            n_fail++;
            $display("FAIL mid_espera_tx: got %0d, want 4", db_estado);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({concede, byte_enviado, iniciar, erro, dado_uart_tx, db_estado} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h, want 0",
                     {concede, byte_enviado, iniciar, erro, dado_uart_tx, db_estado});
        end
        reset = 1'b0;
        pedido = '0;
        n_erro0 = n_erro;
        obs_env.delete();
        repeat (30) tick();
        n_env0 = obs_env.size();
        n_checks++;
        if (n_erro !== n_erro0 || n_env0 !== 0) begin
            n_fail++;
            $display("FAIL mid_no_pulse: got %0d erro %0d env, want 0 and 0",
                     n_erro - n_erro0, n_env0);
        end
        n_checks++;
        if (n_multi !== 0) begin
            n_fail++;
            $display("FAIL grant_onehot: got %0d multi-hot cycles, want 0", n_multi);
        end
    endtask

    initial begin
        reset = 1'b1;
        pedido = '0;
        envia_byte = '0;
        dado = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_non_owner();
        test_timeout();
        test_drop_during_tx();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
